seq_detect_fsm: RTL and testbench
=================================

Name: seq_detect_fsm

Overview:
- Synchronous, parametrised successor to the two-input hand-drawn sequential examples. It detects an ordered sequence of button presses across N_IN input lines.
- Each input is synchronised and debounced, and produces a one-cycle press event. The FSM tracks progress through a programmable sequence, and the output z is stretched so it is visible on the board LEDs.
- It sits between the board buttons and the LED pins in the EGO1 top level.

Parameters:
- N_IN, 2: number of button input channels (>=2).
- SEQ_LEN, 4: number of presses in the target sequence (>=1).
- IDXW, $clog2(N_IN), minimum 1: width of one sequence element.
- SEQ, {2'd1,2'd0,2'd0,2'd1}-style packed vector, width SEQ_LEN*IDXW: element i is SEQ[i*IDXW +: IDXW] and is the channel expected as the i-th press; element 0 is pressed first.
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept an input change (>=2).
- HOLD_CYCLES, 50_000_000: cycles z stays high after a full match (>=1).
- TIMEOUT, 200_000_000: idle cycles after which partial progress is discarded (>=1).

Ports:
- sys_clk_in, input, 1: system clock.
- sys_rst_n, input, 1: reset, asynchronous, active-low.
- btn_in, input, N_IN: raw button levels, asynchronous to sys_clk_in; 1 = pressed.
- z, output, 1: high for HOLD_CYCLES after a complete sequence match.
- busy, output, 1: high while state is MATCHED.
- progress, output, $clog2(SEQ_LEN+1): number of correct presses accepted so far.
- err, output, 1: one-cycle pulse on a wrong or multi-channel press, or on a timeout.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - All synchroniser, debounce, counter and FSM registers clear.
  - z=0, busy=0, progress=0, err=0, state=IDLE.
  - Deassertion of reset is synchronous to sys_clk_in.
  - Reset asserted mid-sequence or mid-hold aborts immediately; no z pulse follows.
- Per-channel front end:
  - Two-flop synchroniser feeds a debounced level deb[i].
  - cnt[i] counts up while the sync output != deb[i] and clears whenever they match.
  - When a mismatch is seen with cnt[i]==DEB_CYCLES-1: deb[i] takes the sync value and cnt[i] clears.
  - press[i] is a registered one-cycle pulse on a 0->1 transition of deb[i].
  - Latency: a clean step on btn_in[i] gives press[i] high exactly DEB_CYCLES+3 rising edges later.
  - Glitches shorter than DEB_CYCLES cycles produce no press.
  - Release (1->0) produces no event.
- Event classification, per cycle:
  - none: press==0.
  - single(c): exactly one bit c set.
  - multi: more than one bit set; always treated as a wrong press.
- FSM states: IDLE, TRACK, MATCHED. Progress register k.
- IDLE (k=0):
  - single(SEQ[0]): if SEQ_LEN==1, go to MATCHED; else k=1 and go to TRACK.
  - Any other event: err pulse, remain IDLE.
- TRACK (1<=k<SEQ_LEN):
  - single(SEQ[k]): k=k+1, and the idle timer clears. If k+1==SEQ_LEN, go to MATCHED and k=SEQ_LEN.
  - Wrong single(c): err pulse. If c==SEQ[0], k=1 (restart) and stay in TRACK; otherwise k=0 and go to IDLE.
  - multi: err pulse, k=0, go to IDLE.
  - No event for TIMEOUT consecutive cycles: err pulse, k=0, go to IDLE.
- MATCHED:
  - z=1 and busy=1; the hold counter runs HOLD_CYCLES cycles, then k=0 and the FSM returns to IDLE.
  - All presses are ignored: no err, no progress change.
- Output timing:
  - progress=k, registered; it updates on the edge following the press pulse.
  - z rises on the edge after the final press pulse.
  - err is registered and appears in the same cycle progress updates.
- Widths: hold, idle and debounce counters are each sized $clog2 of their limit + 1.
- Counters saturate; they never wrap.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum {IDLE, TRACK, MATCHED};
  - helper function seq_elem(seq, i) returning an IDXW-wide index.
- One natural sub-module: btn_debounce (params DEB_CYCLES; ports sys_clk_in, sys_rst_n, raw, level, press), instantiated N_IN times in a generate loop.
- The FSM stays in seq_detect_fsm.

Test Plan:
All tests use N_IN=2, SEQ_LEN=3, SEQ=elements {1,0,1} (press order 1,0,1), DEB_CYCLES=4, HOLD_CYCLES=8, TIMEOUT=32.
- Clean sequence: press btn 1, then 0, then 1, each held 10 cycles with 10-cycle gaps. Required: progress steps 1,2,3; z high exactly 8 cycles starting the edge after the third press pulse; busy matches z; err never asserts.
- Bounce rejection: btn_in[1] toggles high 3 cycles / low 1 cycle five times, then stays high. Required: exactly one press[1], DEB_CYCLES+3=7 edges after the final rising step; progress=1.
- Wrong press with restart: press order 1, 1. Required: err pulses once on the second press; progress stays 1 (restart). Then 0, 1 completes and z asserts.
- Simultaneous press: after progress=2, both buttons rise in the same cycle. Required: one err pulse; progress=0; state IDLE; z stays 0.
- Timeout: press 1, then idle 40 cycles. Required: err pulse 32 cycles after the press event; progress returns to 0.
- Reset mid-hold: assert sys_rst_n low 3 cycles into MATCHED. Required: z, busy and progress go to 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE and a new full sequence matches again.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the button-sequence detector.
// Holds the FSM state encoding and sequence-element extraction.
package seq_detect_pkg;

    localparam int MAX_IDXW  = 8;
    localparam int MAX_SEQ_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        MATCHED
    } state_t;

    // Element i of a packed sequence whose elements are idxw bits wide.
    function automatic logic [MAX_IDXW-1:0] seq_elem(
        input logic [MAX_SEQ_W-1:0] seq,
        input int                   i,
        input int                   idxw
    );
        logic [MAX_IDXW-1:0] mask;
        mask = MAX_IDXW'((1 << idxw) - 1);
        return MAX_IDXW'(seq >> (i * idxw)) & mask;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, counter debounce and a
// registered one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic sys_clk_in,
    input  logic sys_rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // A change is accepted only after DEB_CYCLES consecutive disagreeing samples.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEB_CYCLES - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// Ordered button-sequence detector: per-channel debounce feeding an
// IDLE/TRACK/MATCHED FSM with idle timeout and a stretched match output.
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int                      N_IN        = 2,
    parameter int                      SEQ_LEN     = 4,
    parameter int                      IDXW        = (N_IN > 2) ? $clog2(N_IN) : 1,
    parameter logic [SEQ_LEN*IDXW-1:0] SEQ         = 4'b1001,
    parameter int                      DEB_CYCLES  = 1_000_000,
    parameter int                      HOLD_CYCLES = 50_000_000,
    parameter int                      TIMEOUT     = 200_000_000
) (
    input  logic                             sys_clk_in,
    input  logic                             sys_rst_n,
    input  logic [N_IN-1:0]                  btn_in,
    output logic                             z,
    output logic                             busy,
    output logic [$clog2(SEQ_LEN+1)-1:0]     progress,
    output logic                             err
);

    localparam int KW = $clog2(SEQ_LEN + 1);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam logic [MAX_SEQ_W-1:0] SEQ_EXT = MAX_SEQ_W'(SEQ);

    logic [N_IN-1:0] level;
    logic [N_IN-1:0] press;
    logic [IDXW-1:0] seq_arr [SEQ_LEN];

    for (genvar g = 0; g < N_IN; g++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .sys_clk_in(sys_clk_in),
            .sys_rst_n (sys_rst_n),
            .raw       (btn_in[g]),
            .level     (level[g]),
            .press     (press[g])
        );
    end

    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_seq
        assign seq_arr[g] = IDXW'(seq_elem(SEQ_EXT, g, IDXW));
    end

    // A press pulse can only ever coincide with a high debounced level.
    always_ff @(posedge sys_clk_in) begin
        if (sys_rst_n) begin
            assert ((press & ~level) == '0);
        end
    end

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          err_q, err_n;

    logic          any_ev;
    logic          single_ev;
    logic [IDXW-1:0] ch;
    logic [IDXW-1:0] exp_elem;

    always_comb begin
        any_ev    = |press;
        single_ev = $onehot(press);
        ch        = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (press[i]) ch = IDXW'(i);
        end
        exp_elem = seq_arr[0];
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (k == KW'(i)) exp_elem = seq_arr[i];
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            k        <= '0;
            hold_cnt <= '0;
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            hold_cnt <= hold_n;
            idle_cnt <= idle_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        hold_n  = hold_cnt;
        idle_n  = idle_cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                k_n    = '0;
                hold_n = '0;
                idle_n = '0;
                if (single_ev && ch == seq_arr[0]) begin
                    if (SEQ_LEN == 1) begin
                        state_n = MATCHED;
                        k_n     = KW'(SEQ_LEN);
                    end else begin
                        state_n = TRACK;
                        k_n     = KW'(1);
                    end
                end else if (any_ev) begin
                    err_n = 1'b1;
                end
            end
            TRACK: begin
                if (single_ev && ch == exp_elem) begin
                    idle_n = '0;
                    if (k == KW'(SEQ_LEN - 1)) begin
                        state_n = MATCHED;
                        k_n     = KW'(SEQ_LEN);
                        hold_n  = '0;
                    end else begin
                        k_n = k + KW'(1);
                    end
                end else if (single_ev && ch == seq_arr[0]) begin
                    // A wrong press that is also the first element restarts the sequence.
                    err_n  = 1'b1;
                    k_n    = KW'(1);
                    idle_n = '0;
                end else if (any_ev) begin
                    err_n   = 1'b1;
                    k_n     = '0;
                    state_n = IDLE;
                end else if (idle_cnt >= IW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    k_n     = '0;
                    idle_n  = '0;
                    state_n = IDLE;
                end else begin
                    idle_n = idle_cnt + IW'(1);
                end
            end
            MATCHED: begin
                if (hold_cnt >= HW'(HOLD_CYCLES - 1)) begin
                    state_n = IDLE;
                    k_n     = '0;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    assign z        = (state == MATCHED);
    assign busy     = (state == MATCHED);
    assign progress = k;
    assign err      = err_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: table-driven scenarios, hand-written corner
// sequences and random stimulus, all checked against a behavioural model.
module tb_seq_detect_fsm;
    import seq_detect_pkg::*;

    localparam int N_IN    = 2;
    localparam int SEQ_LEN = 3;
    localparam int DEB     = 4;
    localparam int HOLD    = 8;
    localparam int TMO     = 32;

    logic       sys_clk_in = 1'b0;
    logic       sys_rst_n;
    logic [1:0] btn_in;
    logic       z;
    logic       busy;
    logic [1:0] progress;
    logic       err;

    seq_detect_fsm #(
        .N_IN       (N_IN),
        .SEQ_LEN    (SEQ_LEN),
        .IDXW       (1),
        .SEQ        (3'b101),
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD),
        .TIMEOUT    (TMO)
    ) dut (
        .sys_clk_in(sys_clk_in),
        .sys_rst_n (sys_rst_n),
        .btn_in    (btn_in),
        .z         (z),
        .busy      (busy),
        .progress  (progress),
        .err       (err)
    );

    always #5 sys_clk_in = ~sys_clk_in;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural reference: raw sample history per button, accepted levels,
    // and sequence progress expressed as counts of cycles and presses.
    int seq_m [SEQ_LEN] = '{1, 0, 1};
    bit hist [N_IN][$];
    bit lvl [N_IN];
    bit lvl_p [N_IN];
    bit prs [N_IN];
    int m_prog, m_hold, m_last, cyc;
    bit m_err;

    task automatic model_reset();
        for (int c = 0; c < N_IN; c++) begin
            hist[c].delete();
            repeat (DEB + 2) hist[c].push_back(1'b0);
            lvl[c]   = 1'b0;
            lvl_p[c] = 1'b0;
            prs[c]   = 1'b0;
        end
        m_prog = 0;
        m_hold = 0;
        m_last = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int  nset;
        int  ch;
        bit  flip;
        bit  ev [N_IN];
        cyc++;
        for (int c = 0; c < N_IN; c++) ev[c] = prs[c];
        for (int c = 0; c < N_IN; c++) begin
            prs[c]   = lvl[c] & ~lvl_p[c];
            lvl_p[c] = lvl[c];
            hist[c].push_back(btn_in[c]);
            void'(hist[c].pop_front());
            // The oldest DEB samples are what the synchroniser has delivered so far.
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) if (hist[c][j] == lvl[c]) flip = 1'b0;
            if (flip) lvl[c] = ~lvl[c];
        end
        nset  = int'(ev[0]) + int'(ev[1]);
        ch    = ev[1] ? 1 : 0;
        m_err = 1'b0;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_prog = 0;
        end else if (nset == 0) begin
            if (m_prog > 0 && cyc - m_last >= TMO) begin
                m_err  = 1'b1;
                m_prog = 0;
            end
        end else if (nset == 1 && ch == seq_m[m_prog]) begin
            m_prog++;
            m_last = cyc;
            if (m_prog == SEQ_LEN) m_hold = HOLD;
        end else begin
            m_err = 1'b1;
            if (m_prog > 0 && nset == 1 && ch == seq_m[0]) begin
                m_prog = 1;
                m_last = cyc;
            end else begin
                m_prog = 0;
            end
        end
    endtask

    task automatic tick();
        logic [4:0] act, exp;
        @(posedge sys_clk_in);
        model_step();
        #1;
        act = {z, busy, progress, err};
        exp = {(m_hold > 0), (m_hold > 0), 2'(m_prog), m_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle %0d z/busy/progress/err: got %b expected %b", cyc, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] b, input int n, output int zc, output int ec);
        btn_in = b;
        zc = 0;
        ec = 0;
        repeat (n) begin
            tick();
            zc += int'(z);
            ec += int'(err);
        end
    endtask

    typedef struct {
        logic [1:0] btn;
        int         cyc;
        int         prog;
        int         zcnt;
        int         errs;
    } step_t;

    step_t tbl[$];

    initial begin
        int zc, ec, pc, pat, p1, e1, ztot;

        // Clean sequence 1,0,1
        tbl.push_back('{2'b10, 10, 1, 0, 0});
        tbl.push_back('{2'b00, 10, 1, 0, 0});
        tbl.push_back('{2'b01, 10, 2, 0, 0});
        tbl.push_back('{2'b00, 10, 2, 0, 0});
        tbl.push_back('{2'b10, 10, 3, 3, 0});
        tbl.push_back('{2'b00, 10, 0, 5, 0});
        // Wrong press 1,1 restarts, then 0,1 completes
        tbl.push_back('{2'b10, 10, 1, 0, 0});
        tbl.push_back('{2'b00, 10, 1, 0, 0});
        tbl.push_back('{2'b10, 10, 1, 0, 1});
        tbl.push_back('{2'b00, 10, 1, 0, 0});
        tbl.push_back('{2'b01, 10, 2, 0, 0});
        tbl.push_back('{2'b00, 10, 2, 0, 0});
        tbl.push_back('{2'b10, 10, 3, 3, 0});
        tbl.push_back('{2'b00, 10, 0, 5, 0});
        // Simultaneous press at progress 2
        tbl.push_back('{2'b10, 10, 1, 0, 0});
        tbl.push_back('{2'b00, 10, 1, 0, 0});
        tbl.push_back('{2'b01, 10, 2, 0, 0});
        tbl.push_back('{2'b00, 10, 2, 0, 0});
        tbl.push_back('{2'b11, 10, 0, 0, 1});
        tbl.push_back('{2'b00, 10, 0, 0, 0});

        cyc       = 0;
        btn_in    = 2'b00;
        sys_rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk_in);
        #1;
        check("reset_z", int'(z), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_progress", int'(progress), 0);
        check("reset_err", int'(err), 0);
        @(negedge sys_clk_in);
        sys_rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].btn, tbl[i].cyc, zc, ec);
            check($sformatf("row%0d_progress", i), int'(progress), tbl[i].prog);
            check($sformatf("row%0d_zcount", i), zc, tbl[i].zcnt);
            check($sformatf("row%0d_errcount", i), ec, tbl[i].errs);
        end
        check("simul_state_idle", int'(dut.state), int'(IDLE));

        // Bounce: 3 high / 1 low five times, then a steady press
        pc  = 0;
        pat = 0;
        for (int r = 0; r < 5; r++) begin
            btn_in = 2'b10;
            repeat (3) begin
                tick();
                pc += int'(dut.press[1]);
            end
            btn_in = 2'b00;
            tick();
            pc += int'(dut.press[1]);
        end
        btn_in = 2'b10;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (dut.press[1]) begin
                pc++;
                pat = j;
            end
        end
        check("bounce_press_count", pc, 1);
        check("bounce_press_edge", pat, DEB + 3);
        check("bounce_progress", int'(progress), 1);
        apply(2'b00, 40, zc, ec);
        check("bounce_flush_progress", int'(progress), 0);

        // Timeout after a single correct press
        btn_in = 2'b10;
        p1 = -1;
        e1 = -1;
        ec = 0;
        for (int j = 1; j <= 60; j++) begin
            if (j == 11) btn_in = 2'b00;
            tick();
            if (p1 < 0 && progress == 2'd1) p1 = j;
            if (err) begin
                ec++;
                e1 = j;
            end
        end
        check("timeout_err_count", ec, 1);
        check("timeout_delay", e1 - p1, TMO);
        check("timeout_progress", int'(progress), 0);

        // Reset three cycles into MATCHED
        apply(2'b10, 10, zc, ec);
        apply(2'b00, 10, zc, ec);
        apply(2'b01, 10, zc, ec);
        apply(2'b00, 10, zc, ec);
        apply(2'b10, 10, zc, ec);
        check("prehold_zcount", zc, 3);
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_z", int'(z), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_progress", int'(progress), 0);
        btn_in = 2'b00;
        repeat (3) @(posedge sys_clk_in);
        @(negedge sys_clk_in);
        sys_rst_n = 1'b1;
        model_reset();
        tick();
        check("post_reset_state", int'(dut.state), int'(IDLE));
        ztot = 0;
        apply(2'b10, 10, zc, ec);
        ztot += zc;
        apply(2'b00, 10, zc, ec);
        ztot += zc;
        apply(2'b01, 10, zc, ec);
        ztot += zc;
        apply(2'b00, 10, zc, ec);
        ztot += zc;
        apply(2'b10, 10, zc, ec);
        ztot += zc;
        apply(2'b00, 10, zc, ec);
        ztot += zc;
        check("post_reset_match_zcount", ztot, HOLD);

        // Random button activity against the model
        repeat (300) begin
            btn_in = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 14)) tick();
        end
        btn_in = 2'b00;
        repeat (60) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
